// File: rtl/game_round_ctrl.sv
// Match sequencer for the two-player arms game: tracks HP deaths, the round
// countdown and round scores, and drives the shared 3-bit game state bus.
module game_round_ctrl #(
   parameter int MAX_HP     = 100,
   parameter int ROUND_TIME = 60,
   parameter int POINT_SECS = 3,
   parameter int WIN_POINTS = 2,
   parameter int MAX_ROUNDS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_key,
   input  logic       sec_tick,
   input  logic [7:0] p1_hp,
   input  logic [7:0] p2_hp,
   output logic [2:0] state,
   output logic [6:0] time_left,
   output logic [2:0] p1_score,
   output logic [2:0] p2_score,
   output logic [2:0] round_num,
   output logic [1:0] round_winner
);

   typedef enum logic [2:0] {
      S_MENU  = 3'b000,
      S_GAME  = 3'b001,
      S_P1WIN = 3'b010,
      S_P2WIN = 3'b011,
      S_TIE   = 3'b100,
      S_POINT = 3'b101
   } state_t;

   localparam logic [7:0] HP_MAX   = 8'(MAX_HP);
   localparam logic [6:0] RT       = 7'(ROUND_TIME);
   localparam logic [2:0] HOLD_END = 3'(POINT_SECS);
   localparam logic [2:0] WIN_PTS  = 3'(WIN_POINTS);
   localparam logic [2:0] MAX_RND  = 3'(MAX_ROUNDS);

   state_t     st;
   logic       start_q;
   logic [2:0] hold_cnt;

   logic       start_edge, p1_dead, p2_dead, any_dead, timeout;
   logic       p1_pt, p2_pt, rnd_end;
   logic [2:0] p1_nx, p2_nx, rn_nx;
   state_t     end_st;

   assign state      = st;
   assign start_edge = start_key & ~start_q;
   // hp above MAX_HP means the 8-bit HP counter wrapped below zero
   assign p1_dead    = (p1_hp == 8'd0) || (p1_hp > HP_MAX);
   assign p2_dead    = (p2_hp == 8'd0) || (p2_hp > HP_MAX);
   assign any_dead   = p1_dead | p2_dead;
   assign timeout    = sec_tick && (time_left == 7'd1);

   always_comb begin
      p1_pt   = 1'b0;
      p2_pt   = 1'b0;
      rnd_end = 1'b0;
      if (any_dead) begin
         rnd_end = 1'b1;
         p1_pt   = p2_dead & ~p1_dead;
         p2_pt   = p1_dead & ~p2_dead;
      end else if (timeout) begin
         rnd_end = 1'b1;
         p1_pt   = p1_hp > p2_hp;
         p2_pt   = p2_hp > p1_hp;
      end
   end

   assign p1_nx = p1_score + 3'(p1_pt && (p1_score != 3'd7));
   assign p2_nx = p2_score + 3'(p2_pt && (p2_score != 3'd7));
   assign rn_nx = round_num + 3'(round_num != 3'd7);

   // match outcome is decided on the already-updated scores
   always_comb begin
      end_st = S_POINT;
      if (p1_nx == WIN_PTS)      end_st = S_P1WIN;
      else if (p2_nx == WIN_PTS) end_st = S_P2WIN;
      else if (rn_nx == MAX_RND) begin
         if (p1_nx > p2_nx)      end_st = S_P1WIN;
         else if (p2_nx > p1_nx) end_st = S_P2WIN;
         else                    end_st = S_TIE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st           <= S_MENU;
         time_left    <= RT;
         p1_score     <= 3'd0;
         p2_score     <= 3'd0;
         round_num    <= 3'd0;
         round_winner <= 2'b00;
         hold_cnt     <= 3'd0;
         start_q      <= 1'b0;
      end else begin
         start_q <= start_key;
         case (st)
            S_MENU: begin
               if (start_edge) begin
                  st           <= S_GAME;
                  p1_score     <= 3'd0;
                  p2_score     <= 3'd0;
                  round_num    <= 3'd0;
                  round_winner <= 2'b00;
                  time_left    <= RT;
               end
            end
            S_GAME: begin
               if (rnd_end) begin
                  p1_score     <= p1_nx;
                  p2_score     <= p2_nx;
                  round_num    <= rn_nx;
                  round_winner <= {p2_pt, p1_pt};
                  if (!any_dead) time_left <= 7'd0;
                  hold_cnt     <= 3'd0;
                  st           <= end_st;
               end else if (sec_tick && time_left != 7'd0) begin
                  time_left <= time_left - 7'd1;
               end
            end
            S_POINT: begin
               if (sec_tick) begin
                  hold_cnt <= hold_cnt + 3'd1;
                  if (hold_cnt + 3'd1 == HOLD_END) begin
                     st        <= S_GAME;
                     time_left <= RT;
                  end
               end
            end
            S_P1WIN, S_P2WIN, S_TIE: begin
               if (start_edge) begin
                  st        <= S_MENU;
                  time_left <= RT;
               end
            end
            default: st <= S_MENU;
         endcase
      end
   end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: match flow, deaths, timeouts, resets.
module tb_game_round_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_key;
   logic       sec_tick;
   logic [7:0] p1_hp, p2_hp;
   logic [2:0] state;
   logic [6:0] time_left;
   logic [2:0] p1_score, p2_score, round_num;
   logic [1:0] round_winner;

   int passed = 0;
   int total  = 0;

   game_round_ctrl dut (
      .clk(clk), .rst(rst), .start_key(start_key), .sec_tick(sec_tick),
      .p1_hp(p1_hp), .p2_hp(p2_hp), .state(state), .time_left(time_left),
      .p1_score(p1_score), .p2_score(p2_score), .round_num(round_num),
      .round_winner(round_winner)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         sec_tick = 1'b1;
         step();
         sec_tick = 1'b0;
         step();
      end
   endtask

   task automatic press();
      start_key = 1'b1;
      step();
      start_key = 1'b0;
      step();
   endtask

   task automatic kill(input logic [7:0] h1, input logic [7:0] h2);
      p1_hp = h1;
      p2_hp = h2;
      step();
      p1_hp = 8'd100;
      p2_hp = 8'd100;
   endtask

   task automatic chk_all(input string tag, input logic [2:0] s, input logic [6:0] t,
                          input logic [2:0] s1, input logic [2:0] s2,
                          input logic [2:0] rn, input logic [1:0] rw);
      chk({tag, ".state"}, 32'(state), 32'(s));
      chk({tag, ".time"},  32'(time_left), 32'(t));
      chk({tag, ".p1s"},   32'(p1_score), 32'(s1));
      chk({tag, ".p2s"},   32'(p2_score), 32'(s2));
      chk({tag, ".rnd"},   32'(round_num), 32'(rn));
      chk({tag, ".rw"},    32'(round_winner), 32'(rw));
   endtask

   initial begin
      rst = 1'b1; start_key = 1'b0; sec_tick = 1'b0;
      p1_hp = 8'd100; p2_hp = 8'd100;
      step(); step();
      chk_all("reset", 3'd0, 7'd60, 3'd0, 3'd0, 3'd0, 2'd0);
      rst = 1'b0;
      step();
      ticks(2);
      chk("menu_ignores_tick", 32'(time_left), 32'd60);

      // held key: one edge only
      start_key = 1'b1;
      step();
      chk_all("start", 3'd1, 7'd60, 3'd0, 3'd0, 3'd0, 2'd0);
      repeat (9) step();
      start_key = 1'b0;
      chk("start_held", 32'(state), 32'd1);
      ticks(5);
      chk("countdown5", 32'(time_left), 32'd55);
      press();
      chk("game_ignores_start", 32'(state), 32'd1);
      chk("game_ignores_start_t", 32'(time_left), 32'd55);

      // p2 death, point dwell, second p2 death wins match
      kill(8'd100, 8'd0);
      chk_all("p2dead1", 3'd5, 7'd55, 3'd1, 3'd0, 3'd1, 2'd1);
      ticks(2);
      chk("point_hold2", 32'(state), 32'd5);
      ticks(1);
      chk("point_exit", 32'(state), 32'd1);
      chk("point_exit_t", 32'(time_left), 32'd60);
      kill(8'd100, 8'd0);
      chk_all("p1win", 3'd2, 7'd60, 3'd2, 3'd0, 3'd2, 2'd1);
      press();
      chk("win_to_menu", 32'(state), 32'd0);
      chk("menu_keeps_score", 32'(p1_score), 32'd2);

      // double death, wrap death, timeout into TIE
      press();
      chk_all("restart", 3'd1, 7'd60, 3'd0, 3'd0, 3'd0, 2'd0);
      kill(8'd0, 8'd0);
      chk_all("both_dead", 3'd5, 7'd60, 3'd0, 3'd0, 3'd1, 2'd0);
      ticks(3);
      kill(8'd250, 8'd40);
      chk_all("wrap_dead", 3'd5, 7'd60, 3'd0, 3'd1, 3'd2, 2'd2);
      ticks(3);
      p1_hp = 8'd70; p2_hp = 8'd40;
      ticks(59);
      chk("tick59_state", 32'(state), 32'd1);
      chk("tick59_time", 32'(time_left), 32'd1);
      ticks(1);
      chk_all("timeout_tie", 3'd4, 7'd0, 3'd1, 3'd1, 3'd3, 2'd1);
      p1_hp = 8'd100; p2_hp = 8'd100;
      press();
      chk("tie_to_menu", 32'(state), 32'd0);

      // asynchronous reset mid-GAME with time_left=42, p1_score=1
      press();
      kill(8'd100, 8'd0);
      ticks(3);
      ticks(18);
      chk("pre_rst_time", 32'(time_left), 32'd42);
      chk("pre_rst_p1s", 32'(p1_score), 32'd1);
      rst = 1'b1;
      #1;
      chk_all("async_rst", 3'd0, 7'd60, 3'd0, 3'd0, 3'd0, 2'd0);
      step();
      rst = 1'b0;
      step();

      // timeout draw, then death on the final tick beats timeout
      press();
      p1_hp = 8'd50; p2_hp = 8'd50;
      ticks(60);
      chk_all("timeout_draw", 3'd5, 7'd0, 3'd0, 3'd0, 3'd1, 2'd0);
      p1_hp = 8'd100; p2_hp = 8'd100;
      ticks(3);
      ticks(59);
      p2_hp = 8'd0; sec_tick = 1'b1;
      step();
      sec_tick = 1'b0; p2_hp = 8'd100;
      chk_all("death_on_last_tick", 3'd5, 7'd1, 3'd1, 3'd0, 3'd2, 2'd1);
      ticks(3);
      kill(8'd0, 8'd100);
      chk_all("draw_p1_p2_tie", 3'd4, 7'd60, 3'd1, 3'd1, 3'd3, 2'd2);

      // P2 match win
      press();
      press();
      kill(8'd0, 8'd100);
      ticks(3);
      kill(8'd0, 8'd100);
      chk_all("p2win", 3'd3, 7'd60, 3'd0, 3'd2, 3'd2, 2'd2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
